// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill write path.
// Write address layout is {set, quarter, way} into the data blockram.
package cache_pkg;

    localparam int SET_BITS = 8;
    localparam int WAY_BITS = 2;
    localparam int QW       = 128;
    localparam int LINE_W   = 4 * QW;
    localparam int WADDR_W  = SET_BITS + 2 + WAY_BITS;

    typedef struct packed {
        logic [SET_BITS-1:0] set;
        logic [1:0]          quarter;
        logic [WAY_BITS-1:0] way;
    } data_waddr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } fill_state_e;

    // Pick quarter q out of a full refill line.
    function automatic logic [QW-1:0] quarter_sel(
        input logic [LINE_W-1:0] line,
        input logic [1:0]        q
    );
        return line[q*QW +: QW];
    endfunction

endpackage

// File: rtl/cache_fill_writer.sv
// Refill write sequencer: takes one 512-bit line and writes it as
// four 128-bit quarters into the data blockram, honouring wr_hold.
module cache_fill_writer
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fill_valid,
    output logic                fill_ready,
    input  logic [SET_BITS-1:0] fill_set,
    input  logic [WAY_BITS-1:0] fill_way,
    input  logic [LINE_W-1:0]   fill_line,
    input  logic                wr_hold,
    output logic                wr_en,
    output logic [WADDR_W-1:0]  wr_addr,
    output logic [QW-1:0]       wr_data,
    output logic                fill_done,
    input  logic [SET_BITS-1:0] rd_set,
    output logic                rd_hazard
);

    fill_state_e       state;
    logic [1:0]        beat;
    logic [LINE_W-1:0] line_r;
    data_waddr_t       addr_r;
    logic [QW-1:0]     data_r;
    logic              busy;

    // Address and data of the pending quarter live in registers so the
    // blockram port never sees a combinational path from the fill inputs.
    assign busy       = (state == WRITE);
    assign fill_ready = ~busy;
    assign wr_en      = busy & ~wr_hold;
    assign fill_done  = wr_en & (beat == 2'd3);
    assign wr_addr    = addr_r;
    assign wr_data    = data_r;
    assign rd_hazard  = busy & (rd_set == addr_r.set);

    // Capture on handshake, then advance one quarter per unheld cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            beat   <= 2'd0;
            line_r <= '0;
            addr_r <= '0;
            data_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fill_valid) begin
                        line_r         <= fill_line;
                        addr_r.set     <= fill_set;
                        addr_r.quarter <= 2'd0;
                        addr_r.way     <= fill_way;
                        data_r         <= quarter_sel(fill_line, 2'd0);
                        beat           <= 2'd0;
                        state          <= WRITE;
                    end
                end
                WRITE: begin
                    if (!wr_hold) begin
                        if (beat == 2'd3) begin
                            beat  <= 2'd0;
                            state <= IDLE;
                        end else begin
                            beat           <= beat + 2'd1;
                            addr_r.quarter <= beat + 2'd1;
                            data_r         <= quarter_sel(line_r, beat + 2'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
